// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the byte-serial transmitter
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/serial_tx_baud_gen.sv
// rtl/serial_tx_baud_gen.sv - bit-period counter with a one-cycle end-of-bit pulse
module baud_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = !clear && (cnt_q == LAST);

  // Wrapping at LAST doubles as the per-bit restart, so every period is exact.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - byte-serial async transmitter, 8 data bits LSB first,
// optional parity and one or two stop bits, registered tx/status
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       status
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       status_q, status_d;
  logic       bit_end;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (sysclk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      status_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          shift_d   = data;
          bit_idx_d = '0;
          // Parity is fixed at accept because the shift register is consumed.
          par_d     = (^data) ^ (PARITY == PAR_ODD);
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    tx_d     = 1'b1;
    status_d = (state_d == ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx     = tx_q;
  assign status = status_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed vector bench for serial_tx with CLKS_PER_BIT=4
module tb_serial_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [7:0] data_v [3];
  logic [2:0] tx_v;
  logic [2:0] status_v;

  int vectors;
  int miscompares;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t tbl [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
    .sysclk(clk), .rst(rst), .data(data_v[0]), .start(start_v[0]),
    .tx(tx_v[0]), .status(status_v[0]));

  serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_p2s1 (
    .sysclk(clk), .rst(rst), .data(data_v[1]), .start(start_v[1]),
    .tx(tx_v[1]), .status(status_v[1]));

  serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_p1s2 (
    .sysclk(clk), .rst(rst), .data(data_v[2]), .start(start_v[2]),
    .tx(tx_v[2]), .status(status_v[2]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] frame_p0(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  task automatic send(input int idx, input logic [7:0] d, input int nbits,
                      input logic [11:0] exp, input int poke);
    logic [11:0] first;
    logic [11:0] unstable;
    logic        st_bad;
    logic        idle_bad;
    int          f;
    f        = nbits * CPB;
    first    = '0;
    unstable = '0;
    st_bad   = 1'b0;
    idle_bad = 1'b0;
    @(negedge clk);
    data_v[idx]  = d;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    for (int c = 0; c < f; c++) begin
      if (c > 0) @(negedge clk);
      if (c == poke) begin
        data_v[idx]  = 8'hFF;
        start_v[idx] = 1'b1;
      end
      if (c == poke + 1) start_v[idx] = 1'b0;
      if (c % CPB == 0) first[c / CPB] = tx_v[idx];
      else if (tx_v[idx] !== first[c / CPB]) unstable[c / CPB] = 1'b1;
      if (status_v[idx] !== 1'b0) st_bad = 1'b1;
    end
    for (int b = 0; b < nbits; b++)
      chk($sformatf("dut%0d data %h bit%0d {unstable,level}", idx, d, b),
          {30'd0, unstable[b], first[b]}, {30'd0, 1'b0, exp[b]});
    chk($sformatf("dut%0d data %h status low whole frame", idx, d), {31'd0, st_bad}, 32'd0);
    for (int c = 0; c < 2 * f; c++) begin
      @(negedge clk);
      if (tx_v[idx] !== 1'b1 || status_v[idx] !== 1'b1) idle_bad = 1'b1;
    end
    chk($sformatf("dut%0d data %h idle after frame", idx, d), {31'd0, idle_bad}, 32'd0);
  endtask

  initial begin
    logic       cap_tx [82];
    logic       cap_st [82];
    logic       bad;
    logic [11:0] exp_f;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start_v     = '0;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

    tbl[0] = '{0, 8'h41, 10, 12'h282};
    tbl[1] = '{1, 8'h41, 11, 12'h482};
    tbl[2] = '{2, 8'h41, 12, 12'hE82};
    tbl[3] = '{0, 8'hA5, 10, 12'h34A};
    tbl[4] = '{1, 8'h07, 11, 12'h60E};
    tbl[5] = '{2, 8'h00, 12, 12'hE00};

    repeat (2) @(negedge clk);
    chk("reset tx", {29'd0, tx_v}, 32'h7);
    chk("reset status", {29'd0, status_v}, 32'h7);
    rst = 1'b0;

    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_v !== 3'b111 || status_v !== 3'b111) bad = 1'b1;
    end
    chk("idle 100 cycles after reset", {31'd0, bad}, 32'd0);

    for (int i = 0; i < 6; i++)
      send(tbl[i].dut, tbl[i].data, tbl[i].nbits, tbl[i].frame, -1);

    // Back-to-back: start held, data swapped mid-frame
    @(negedge clk);
    data_v[0]  = 8'h55;
    start_v[0] = 1'b1;
    for (int c = 0; c < 82; c++) begin
      @(negedge clk);
      if (c == 10) data_v[0] = 8'hAA;
      if (c == 41) start_v[0] = 1'b0;
      cap_tx[c] = tx_v[0];
      cap_st[c] = status_v[0];
    end
    exp_f = frame_p0(8'h55);
    bad = 1'b0;
    for (int c = 0; c < 40; c++)
      if (cap_tx[c] !== exp_f[c / CPB] || cap_st[c] !== 1'b0) bad = 1'b1;
    chk("b2b first frame carries 55", {31'd0, bad}, 32'd0);
    chk("b2b gap cycle {tx,status}", {30'd0, cap_tx[40], cap_st[40]}, 32'h3);
    chk("b2b second accept at +41 {tx,status}", {30'd0, cap_tx[41], cap_st[41]}, 32'h0);
    exp_f = frame_p0(8'hAA);
    bad = 1'b0;
    for (int c = 41; c < 81; c++)
      if (cap_tx[c] !== exp_f[(c - 41) / CPB] || cap_st[c] !== 1'b0) bad = 1'b1;
    chk("b2b second frame carries AA", {31'd0, bad}, 32'd0);
    chk("b2b idle after second {tx,status}", {30'd0, cap_tx[81], cap_st[81]}, 32'h3);
    repeat (50) @(negedge clk);
    chk("b2b no third frame status", {31'd0, status_v[0]}, 32'd1);

    // Start/data poked mid-frame must be ignored
    send(0, 8'h41, 10, 12'h282, 15);

    // Reset pulse shorter than a clock, 17 cycles into a frame
    @(negedge clk);
    data_v[0]  = 8'h3C;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int c = 1; c <= 17; c++) @(negedge clk);
    chk("pre-abort status low", {31'd0, status_v[0]}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort immediate {tx,status}", {30'd0, tx_v[0], status_v[0]}, 32'h3);
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || status_v[0] !== 1'b1) bad = 1'b1;
    end
    chk("idle after abort", {31'd0, bad}, 32'd0);
    send(0, 8'h0F, 10, 12'h21E, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Byte-serial asynchronous transmitter. It sits directly downstream of the word-sequencer: it takes one byte per handshake and drives the board's serial output pin. The frame is 8N1 by default, with parity and stop-bit count set by parameter. A `status` (ready) line tells the sequencer when the next byte may be presented.

Parameters:
- CLKS_PER_BIT, 5208, sysclk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  8  byte to send; sampled only on the accept edge.
- start  in  1  level request; accepted only while status=1.
- tx  out  1  serial line; idles high.
- status  out  1  1 = idle/ready to accept, 0 = frame in progress.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, status=1, state=IDLE.
  - Baud counter and bit index are cleared.
  - Asserting rst mid-frame aborts the frame immediately; tx returns high with no partial stop bit.
- Outputs: all registered; there is no combinational path from start or data to tx or status.
- Accept rule: a rising sysclk edge with state=IDLE and start=1 causes, at that edge:
  - data is latched into the shift register;
  - state becomes START, tx becomes 0, status becomes 0.
- Once accepted, changes on start or data have no effect until the frame completes.
- start=1 while status=0 is ignored; nothing is queued.
- States and bit periods:
  - IDLE: tx=1, status=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: bits 0..7, LSB first, each held CLKS_PER_BIT cycles; the bit index wraps 7 -> leave DATA.
  - PARITY: skipped when PARITY=0. The bit is the XOR of the latched byte, inverted for odd parity, so the total count of ones is even (PARITY=2) or odd (PARITY=1). Held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then state becomes IDLE.
- Timing is exact:
  - Frame length F = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - tx changes only on bit-period boundaries, measured from the accept edge.
- status returns to 1 on the same edge that ends the last stop period, i.e. F cycles after the accept edge.
- Back-to-back frames with start held high: the next accept occurs on the following edge. The line therefore sees exactly 1 extra idle-high sysclk cycle between frames, and each frame carries a freshly sampled byte.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state/bit transition and on accept, so there is no drift.
- The sequencer handshake matches this exactly:
  - wait for status=1;
  - drive data and start=1;
  - status falls on the next edge, after which start may be dropped.

Decomposition:
- Package serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the default CLKS_PER_BIT.
- One sub-module, baud_gen. It has a clear input and CLKS_PER_BIT as a parameter, and emits a single-cycle `bit_end` pulse when the count reaches CLKS_PER_BIT-1.
- serial_tx holds the FSM, the shift register, the bit index and parity.

Test Plan:
- The bench runs with CLKS_PER_BIT=4.
- Scenario 1: PARITY=0, STOP_BITS=1, data=8'h41, start pulsed for 1 cycle while idle. Required response:
  - tx levels 0,1,0,0,0,0,0,1,0,1, each held exactly 4 cycles;
  - status low for exactly 40 cycles;
  - status high and tx high afterwards.
- Scenario 2: PARITY=2 with data=8'h41 gives parity bit 0, frame 44 cycles; PARITY=1 with the same data gives parity bit 1. With STOP_BITS=2, tx is high for 8 cycles at the end of the frame.
- Scenario 3: start held high, data=8'h55 then changed to 8'hAA 10 cycles into the frame. Required response:
  - the first frame carries 55;
  - the second frame carries AA and starts exactly 41 cycles after the first accept (1-cycle idle gap).
- Scenario 4: start pulsed while status=0, mid-frame, with data=8'hFF. Required response: no effect on the current frame and no extra frame afterwards.
- Scenario 5: rst asserted 17 cycles into a frame, for a duration shorter than 1 clock. Required response:
  - tx=1 and status=1 immediately, before the next sysclk edge;
  - after release, a new start with 8'h0F produces a clean, complete frame.
- Scenario 6: immediately after reset, with no start, run 100 cycles. Required response: tx constant 1 and status constant 1.
